// File: rtl/dispatcher_pkg.sv
// dispatcher_pkg: shared state encoding, counter width and index helper for the dispatcher
package dispatcher_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      CAPTURE = 2'd2,
      OFFER   = 2'd3
   } state_t;

   localparam int CNT_W = 16;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 == n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/dispatcher_rr_pick.sv
// rr_pick: combinational round-robin picker searching upward from the slot after last
module rr_pick #(
   parameter int N = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic found;
   int   j;

   // first set request at last+1, last+2, ... with wrap-around; last itself is tried last
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 1; i <= N; i++) begin
         j = (int'(last) + i) % N;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/dispatcher.sv
// dispatcher: pops FIFO words one at a time and offers each to a round-robin chosen reader
module dispatcher
   import dispatcher_pkg::*;
#(
   parameter int NUM_READERS = 2,
   parameter int DATA_W      = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_empty,
   output logic                   o_re,
   input  logic [DATA_W-1:0]      i_rdata,
   input  logic [NUM_READERS-1:0] i_ready,
   output logic [NUM_READERS-1:0] o_valid,
   output logic [DATA_W-1:0]      o_data,
   input  logic [NUM_READERS-1:0] i_ack,
   output logic [CNT_W-1:0]       o_delivered
);

   localparam int IW = $clog2(NUM_READERS);

   state_t                 state, state_nxt;
   logic [NUM_READERS-1:0] grant, pick;
   logic [IW-1:0]          grant_idx, pick_idx, ptr, last;
   logic                   start, acked;

   // ptr is the first index to search; the picker wants the index just before it
   assign last  = (ptr == '0) ? IW'(NUM_READERS - 1) : ptr - IW'(1);
   assign start = (state == IDLE) && !i_empty && (|i_ready);
   assign acked = (state == OFFER) && i_ack[grant_idx];

   rr_pick #(.N(NUM_READERS)) u_pick (
      .req  (i_ready),
      .last (last),
      .gnt  (pick),
      .idx  (pick_idx)
   );

   // state register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_nxt;
   end

   // next state and strobes; the word is popped only when a reader is waiting for it
   always_comb begin
      state_nxt = state;
      o_re      = 1'b0;
      o_valid   = '0;
      case (state)
         IDLE:    state_nxt = start ? FETCH : IDLE;
         FETCH:   begin state_nxt = CAPTURE; o_re = 1'b1; end
         CAPTURE: state_nxt = OFFER;
         default: begin state_nxt = acked ? IDLE : OFFER; o_valid = grant; end
      endcase
   end

   // grant latches at the IDLE decision; the search pointer only moves on an accepted word
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         grant     <= '0;
         grant_idx <= '0;
         ptr       <= '0;
      end else begin
         if (start) begin
            grant     <= pick;
            grant_idx <= pick_idx;
         end
         if (acked) ptr <= IW'(wrap_inc(int'(grant_idx), NUM_READERS));
      end
   end

   // FIFO read data arrives the cycle after o_re and is held for the whole offer
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)            o_data <= '0;
      else if (state == CAPTURE) o_data <= i_rdata;
   end

   // delivered-word counter, wraps naturally at its width
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) o_delivered <= '0;
      else if (acked) o_delivered <= o_delivered + CNT_W'(1);
   end

endmodule

// File: tb/tb_dispatcher.sv
// tb_dispatcher: directed scenario checks for the dispatcher
module tb_dispatcher;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_empty = 1'b1;
   logic        o_re;
   logic [7:0]  i_rdata = 8'h00;
   logic [1:0]  i_ready = 2'b00;
   logic [1:0]  o_valid;
   logic [7:0]  o_data;
   logic [1:0]  i_ack = 2'b00;
   logic [15:0] o_delivered;

   int passed = 0;
   int total  = 0;

   dispatcher #(.NUM_READERS(2), .DATA_W(8)) dut (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_empty     (i_empty),
      .o_re        (o_re),
      .i_rdata     (i_rdata),
      .i_ready     (i_ready),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .i_ack       (i_ack),
      .o_delivered (o_delivered)
   );

   always #5 i_clk = ~i_clk;

   task automatic do_reset();
      i_ready   = 2'b00;
      i_ack     = 2'b00;
      i_reset_n = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      total++; if (o_re !== 1'b0) $display("FAIL reset_re got %b want 0", o_re); else passed++;
      total++; if (o_valid !== 2'b00) $display("FAIL reset_valid got %b want 00", o_valid); else passed++;
      total++; if (o_data !== 8'h00) $display("FAIL reset_data got %h want 00", o_data); else passed++;
      total++; if (o_delivered !== 16'h0000) $display("FAIL reset_count got %h want 0000", o_delivered); else passed++;
   endtask

   task automatic test_basic();
      i_empty = 1'b0; i_ready = 2'b01; i_rdata = 8'hA5; i_ack = 2'b01;
      @(negedge i_clk);
      i_reset_n = 1'b1;
      #1;
      total++; if (o_re !== 1'b0) $display("FAIL basic_re_c1 got %b want 0", o_re); else passed++;
      @(negedge i_clk);
      total++; if (o_re !== 1'b1) $display("FAIL basic_re_c2 got %b want 1", o_re); else passed++;
      @(negedge i_clk);
      total++; if (o_re !== 1'b0) $display("FAIL basic_re_c3 got %b want 0", o_re); else passed++;
      total++; if (o_valid !== 2'b00) $display("FAIL basic_valid_c3 got %b want 00", o_valid); else passed++;
      @(negedge i_clk);
      total++; if (o_valid !== 2'b01) $display("FAIL basic_valid_c4 got %b want 01", o_valid); else passed++;
      total++; if (o_data !== 8'hA5) $display("FAIL basic_data_c4 got %h want a5", o_data); else passed++;
      total++; if (o_re !== 1'b0) $display("FAIL basic_re_c4 got %b want 0", o_re); else passed++;
      i_ready = 2'b00;
      @(negedge i_clk);
      total++; if (o_valid !== 2'b00) $display("FAIL basic_valid_c5 got %b want 00", o_valid); else passed++;
      total++; if (o_delivered !== 16'd1) $display("FAIL basic_count got %0d want 1", o_delivered); else passed++;
   endtask

   task automatic test_round_robin();
      logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
      logic [1:0] grants [3] = '{2'b01, 2'b10, 2'b01};
      do_reset();
      i_empty = 1'b0; i_ready = 2'b11; i_ack = 2'b11;
      for (int k = 0; k < 3; k++) begin
         i_rdata = words[k];
         repeat (3) @(negedge i_clk);
         total++; if (o_valid !== grants[k]) $display("FAIL rr_valid_%0d got %b want %b", k, o_valid, grants[k]); else passed++;
         total++; if (o_data !== words[k]) $display("FAIL rr_data_%0d got %h want %h", k, o_data, words[k]); else passed++;
         if (k == 2) i_ready = 2'b00;
         @(negedge i_clk);
      end
      total++; if (o_delivered !== 16'd3) $display("FAIL rr_count got %0d want 3", o_delivered); else passed++;
      total++; if (o_valid !== 2'b00) $display("FAIL rr_valid_end got %b want 00", o_valid); else passed++;
   endtask

   task automatic test_hold();
      i_ready = 2'b10; i_ack = 2'b00; i_rdata = 8'h5C;
      repeat (3) @(negedge i_clk);
      i_rdata = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         total++; if (o_valid !== 2'b10) $display("FAIL hold_valid_%0d got %b want 10", i, o_valid); else passed++;
         total++; if (o_data !== 8'h5C) $display("FAIL hold_data_%0d got %h want 5c", i, o_data); else passed++;
         i_ack = (i == 1) ? 2'b01 : 2'b00;
         @(negedge i_clk);
      end
      total++; if (o_delivered !== 16'd3) $display("FAIL hold_count_wait got %0d want 3", o_delivered); else passed++;
      i_ack = 2'b10; i_ready = 2'b00;
      @(negedge i_clk);
      total++; if (o_valid !== 2'b00) $display("FAIL hold_valid_end got %b want 00", o_valid); else passed++;
      total++; if (o_delivered !== 16'd4) $display("FAIL hold_count got %0d want 4", o_delivered); else passed++;
      i_ack = 2'b00;
   endtask

   task automatic test_ready_drop();
      i_ready = 2'b11; i_rdata = 8'h77;
      @(negedge i_clk);
      @(negedge i_clk);
      i_ready = 2'b00;
      @(negedge i_clk);
      total++; if (o_valid !== 2'b01) $display("FAIL drop_valid_rr got %b want 01", o_valid); else passed++;
      i_ack = 2'b01;
      @(negedge i_clk);
      i_ack = 2'b00; i_ready = 2'b10; i_rdata = 8'h66;
      @(negedge i_clk);
      @(negedge i_clk);
      i_ready = 2'b00;
      @(negedge i_clk);
      total++; if (o_valid !== 2'b10) $display("FAIL drop_valid got %b want 10", o_valid); else passed++;
      total++; if (o_data !== 8'h66) $display("FAIL drop_data got %h want 66", o_data); else passed++;
      @(negedge i_clk);
      total++; if (o_valid !== 2'b10) $display("FAIL drop_valid_wait got %b want 10", o_valid); else passed++;
      i_ack = 2'b10;
      @(negedge i_clk);
      total++; if (o_valid !== 2'b00) $display("FAIL drop_valid_end got %b want 00", o_valid); else passed++;
      total++; if (o_delivered !== 16'd6) $display("FAIL drop_count got %0d want 6", o_delivered); else passed++;
      i_ack = 2'b00;
   endtask

   task automatic test_empty();
      int bad_re = 0;
      int bad_valid = 0;
      i_empty = 1'b1; i_ready = 2'b11;
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         if (o_re !== 1'b0) bad_re++;
         if (o_valid !== 2'b00) bad_valid++;
      end
      total++; if (bad_re != 0) $display("FAIL empty_re got %0d high cycles want 0", bad_re); else passed++;
      total++; if (bad_valid != 0) $display("FAIL empty_valid got %0d offer cycles want 0", bad_valid); else passed++;
      i_ready = 2'b00; i_empty = 1'b0;
   endtask

   task automatic test_reset_mid_offer();
      i_ready = 2'b01; i_rdata = 8'h99; i_ack = 2'b00;
      repeat (3) @(negedge i_clk);
      total++; if (o_valid !== 2'b01) $display("FAIL rmid_valid_pre got %b want 01", o_valid); else passed++;
      i_reset_n = 1'b0;
      #1;
      total++; if (o_valid !== 2'b00) $display("FAIL rmid_valid got %b want 00", o_valid); else passed++;
      total++; if (o_data !== 8'h00) $display("FAIL rmid_data got %h want 00", o_data); else passed++;
      total++; if (o_delivered !== 16'd0) $display("FAIL rmid_count got %0d want 0", o_delivered); else passed++;
      i_ready = 2'b00; i_ack = 2'b01;
      @(negedge i_clk);
      i_reset_n = 1'b1;
      repeat (3) @(negedge i_clk);
      total++; if (o_delivered !== 16'd0) $display("FAIL rmid_count_after got %0d want 0", o_delivered); else passed++;
      total++; if (o_valid !== 2'b00) $display("FAIL rmid_valid_after got %b want 00", o_valid); else passed++;
      i_ack = 2'b00;
   endtask

   task automatic test_wrap();
      force dut.o_delivered = 16'hFFFE;
      #1;
      release dut.o_delivered;
      i_empty = 1'b0; i_ready = 2'b01; i_ack = 2'b01; i_rdata = 8'h42;
      repeat (4) @(negedge i_clk);
      total++; if (o_delivered !== 16'hFFFF) $display("FAIL wrap_ffff got %h want ffff", o_delivered); else passed++;
      repeat (3) @(negedge i_clk);
      i_ready = 2'b00;
      @(negedge i_clk);
      total++; if (o_delivered !== 16'h0000) $display("FAIL wrap_zero got %h want 0000", o_delivered); else passed++;
      i_ack = 2'b00;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_hold();
      test_ready_drop();
      test_empty();
      test_reset_mid_offer();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
